// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the sram_ctrl front-end: FSM state encoding and default strobe length.
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StSetup     = 3'd1,
    StStrobe    = 3'd2,
    StHold      = 3'd3,
    StClrSetup  = 3'd4,
    StClrStrobe = 3'd5,
    StClrHold   = 3'd6
  } state_e;

  localparam int unsigned DefStrobeCycles = 2;

  function automatic logic is_clr(state_e s);
    return (s == StClrSetup) || (s == StClrStrobe) || (s == StClrHold);
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// Synchronous valid/ready front-end for an asynchronous SRAM: phases cs/strobes around a
// registered address/data, captures read data, and optionally zero-fills the array after reset.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned    AW             = 8,
  parameter int unsigned    DW             = 8,
  parameter int unsigned    STROBE_CYCLES  = DefStrobeCycles,
  parameter bit             CLEAR_ON_RESET = 1'b1,
  parameter logic [DW-1:0]  CLEAR_VAL      = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          busy,
  output logic          sram_cs,
  output logic          sram_wr,
  output logic          sram_rd,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  input  logic [DW-1:0] sram_dout
);

  localparam state_e     ResetState = CLEAR_ON_RESET ? StClrSetup : StIdle;
  localparam logic [3:0] StrobeLoad = 4'(STROBE_CYCLES);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] din_q, din_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          cs_q, cs_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clr_addr_d = clr_addr_q;
    we_d       = we_q;
    addr_d     = addr_q;
    din_d      = din_q;
    rdata_d    = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          din_d   = req_wdata;
          state_d = StSetup;
        end
      end
      StSetup: begin
        cnt_d   = StrobeLoad;
        state_d = StStrobe;
      end
      StStrobe: begin
        if (cnt_q == 4'd1) begin
          state_d = StHold;
          if (!we_q) rdata_d = sram_dout;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: state_d = StIdle;
      StClrSetup: begin
        cnt_d   = StrobeLoad;
        din_d   = CLEAR_VAL;
        state_d = StClrStrobe;
      end
      StClrStrobe: begin
        if (cnt_q == 4'd1) state_d = StClrHold;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StClrHold: begin
        if (clr_addr_q == '1) begin
          state_d = StIdle;
        end else begin
          clr_addr_d = clr_addr_q + AW'(1);
          addr_d     = clr_addr_q + AW'(1);
          din_d      = CLEAR_VAL;
          state_d    = StClrSetup;
        end
      end
      default: state_d = StIdle;
    endcase
    // Registered so that cs stays low on the first cycle out of reset.
    cs_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ResetState;
      cnt_q      <= '0;
      clr_addr_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rdata_q    <= '0;
      cs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clr_addr_q <= clr_addr_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      rdata_q    <= rdata_d;
      cs_q       <= cs_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign busy      = is_clr(state_q);
  assign rsp_valid = (state_q == StHold) && !we_q;
  assign rsp_rdata = rdata_q;
  assign sram_cs   = cs_q;
  assign sram_addr = addr_q;
  assign sram_din  = din_q;
  assign sram_wr   = !(((state_q == StStrobe) && we_q) || (state_q == StClrStrobe));
  assign sram_rd   = !((state_q == StStrobe) && !we_q);

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench: a default-configured controller (clear sweep, 2-cycle strobe) and a
// short-strobe no-clear variant, each wired to a behavioural SRAM array.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst;
  logic [1:0]      req_valid, req_ready, req_we;
  logic [1:0][7:0] req_addr, req_wdata;
  logic [1:0]      rsp_valid, busy, sram_cs, sram_wr, sram_rd;
  logic [1:0][7:0] rsp_rdata, sram_addr, sram_din, sram_dout;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic       fill0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rd_lo = 0;
  int wr_lo = 0;
  int rspv  = 0;

  sram_ctrl #(
    .AW(8), .DW(8), .STROBE_CYCLES(DefStrobeCycles), .CLEAR_ON_RESET(1'b1), .CLEAR_VAL(8'h00)
  ) u_dut0 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .busy(busy[0]),
    .sram_cs(sram_cs[0]), .sram_wr(sram_wr[0]), .sram_rd(sram_rd[0]),
    .sram_addr(sram_addr[0]), .sram_din(sram_din[0]), .sram_dout(sram_dout[0])
  );

  sram_ctrl #(
    .AW(8), .DW(8), .STROBE_CYCLES(1), .CLEAR_ON_RESET(1'b0), .CLEAR_VAL(8'h00)
  ) u_dut1 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .busy(busy[1]),
    .sram_cs(sram_cs[1]), .sram_wr(sram_wr[1]), .sram_rd(sram_rd[1]),
    .sram_addr(sram_addr[1]), .sram_din(sram_din[1]), .sram_dout(sram_dout[1])
  );

  // Behavioural SRAM: write while cs && !wr, combinational read.
  always @(posedge clk) begin
    if (fill0) begin
      for (int i = 0; i < 256; i++) mem0[i] <= 8'hEE;
    end else if (sram_cs[0] && !sram_wr[0]) begin
      mem0[sram_addr[0]] <= sram_din[0];
    end
    if (sram_cs[1] && !sram_wr[1]) mem1[sram_addr[1]] <= sram_din[1];
    cyc <= cyc + 1;
  end
  assign sram_dout[0] = mem0[sram_addr[0]];
  assign sram_dout[1] = mem1[sram_addr[1]];

  always @(negedge clk) begin
    if (!sram_rd[0]) rd_lo = rd_lo + 1;
    if (!sram_wr[0]) wr_lo = wr_lo + 1;
    if (rsp_valid[0]) rspv = rspv + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input int d);
    int g = 0;
    while (!req_ready[d] && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("ready_wait", 32'(req_ready[d]), 32'd1);
  endtask

  // Called at a negedge; returns at the negedge where req_ready is back.
  task automatic access(input int d, input logic we, input logic [7:0] a, input logic [7:0] wd,
                        output logic [7:0] rdat, output int lat, output int wlow);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    wait_ready(d);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    rdat = '0;
    lat  = 0;
    wlow = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!sram_wr[d]) wlow++;
      if (rsp_valid[d] && lat == 0) begin
        lat  = i;
        rdat = rsp_rdata[d];
      end
      if (req_ready[d]) break;
    end
  endtask

  initial begin
    logic [7:0] rdat;
    int lat, wlow, n, nz, t1, t2, rd0, wr0, rv0, g;
    rst       = 2'b11;
    fill0     = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    fill0 = 1'b0;
    @(negedge clk);
    check("rst_cs",    32'(sram_cs[0]),   32'd0);
    check("rst_wr",    32'(sram_wr[0]),   32'd1);
    check("rst_rd",    32'(sram_rd[0]),   32'd1);
    check("rst_addr",  32'(sram_addr[0]), 32'd0);
    check("rst_din",   32'(sram_din[0]),  32'd0);
    check("rst_rspv",  32'(rsp_valid[0]), 32'd0);
    check("rst_rdata", 32'(rsp_rdata[0]), 32'd0);
    check("rst_busy",  32'(busy[0]),      32'd1);
    check("rst_ready", 32'(req_ready[0]), 32'd0);
    rst = 2'b00;
    check("noclr_ready", 32'(req_ready[1]), 32'd1);
    check("noclr_busy",  32'(busy[1]),      32'd0);

    // Clear sweep while the host pokes read requests that must be ignored.
    rd0 = rd_lo; wr0 = wr_lo; rv0 = rspv;
    n = 0;
    req_we[0] = 1'b0;
    req_addr[0] = 8'h0F;
    while (busy[0] && n < 3000) begin
      n++;
      req_valid[0] = n[0];
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    check("sweep_len",   32'(n),            32'd1024);
    check("sweep_ready", 32'(req_ready[0]), 32'd1);
    check("sweep_rd",    32'(rd_lo - rd0),  32'd0);
    check("sweep_wr",    32'(wr_lo - wr0),  32'd512);
    check("sweep_rspv",  32'(rspv - rv0),   32'd0);
    nz = 0;
    for (int i = 0; i < 256; i++) if (mem0[i] !== 8'h00) nz++;
    check("sweep_fill", 32'(nz), 32'd0);

    access(0, 1'b0, 8'h0F, 8'h00, rdat, lat, wlow);
    check("rd_clr_data", 32'(rdat), 32'h00);
    check("rd_clr_lat",  32'(lat),  32'd4);
    access(0, 1'b1, 8'h0F, 8'hAA, rdat, lat, wlow);
    check("wr_low_len",  32'(wlow), 32'd2);
    access(0, 1'b0, 8'h0F, 8'h00, rdat, lat, wlow);
    check("rd_aa_data",  32'(rdat), 32'hAA);
    check("rd_aa_lat",   32'(lat),  32'd4);

    // Back-to-back writes with req_valid held high.
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h00; req_wdata[0] = 8'h11;
    wait_ready(0);
    @(posedge clk);
    #1 t1 = cyc;
    req_addr[0] = 8'hFF; req_wdata[0] = 8'h22;
    @(negedge clk);
    wait_ready(0);
    @(posedge clk);
    #1 t2 = cyc;
    req_valid[0] = 1'b0;
    @(negedge clk);
    wait_ready(0);
    check("b2b_gap", 32'(t2 - t1), 32'd5);
    access(0, 1'b0, 8'h00, 8'h00, rdat, lat, wlow);
    check("b2b_rd00", 32'(rdat), 32'h11);
    access(0, 1'b0, 8'hFF, 8'h00, rdat, lat, wlow);
    check("b2b_rdff", 32'(rdat), 32'h22);

    // Short-strobe, no-clear variant.
    access(1, 1'b1, 8'h05, 8'h33, rdat, lat, wlow);
    check("s1_wr_low", 32'(wlow), 32'd1);
    access(1, 1'b0, 8'h05, 8'h00, rdat, lat, wlow);
    check("s1_rd_data", 32'(rdat), 32'h33);
    check("s1_rd_lat",  32'(lat),  32'd3);

    // Reset in the middle of a read strobe.
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'h0F;
    wait_ready(0);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    g = 0;
    while (sram_rd[0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("mid_strobe_seen", 32'(sram_rd[0]), 32'd0);
    rv0 = rspv;
    rst[0] = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rd",   32'(sram_rd[0]),   32'd1);
    check("mid_cs",   32'(sram_cs[0]),   32'd0);
    check("mid_rspv", 32'(rsp_valid[0]), 32'd0);
    check("mid_busy", 32'(busy[0]),      32'd1);
    @(negedge clk);
    rst[0] = 1'b0;
    g = 0;
    while (sram_wr[0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("restart_addr", 32'(sram_addr[0]), 32'd0);
    g = 0;
    while (busy[0] && g < 3000) begin
      @(negedge clk);
      g++;
    end
    check("restart_done", 32'(busy[0]),    32'd0);
    check("mid_no_rspv",  32'(rspv - rv0), 32'd0);
    access(0, 1'b0, 8'h0F, 8'h00, rdat, lat, wlow);
    check("restart_rd", 32'(rdat), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
